// File: rtl/sqrt_param_pkg.sv
// Shared definitions for the iterative square-root block and its add/sub handshake.
package sqrt_param_pkg;

    // FSM state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WORK     = 2'd1,
        ST_WAIT_SUB = 2'd2,
        ST_DONE     = 2'd3
    } sqrt_state_t;

    // Operation select for the shared add/sub unit; common to all of its clients
    localparam logic ADDSUB_SUB = 1'b0;
    localparam logic ADDSUB_ADD = 1'b1;

endpackage

// File: rtl/sqrt_param.sv
// Iterative integer square root: y = floor(sqrt(x)), rem = x - y*y.
// All subtractions are delegated to an external shared add/sub unit via req/ready.
module sqrt_param
    import sqrt_param_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     x_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH/2-1:0]   y_bo,
    output logic [WIDTH/2:0]     rem_bo,
    output logic                 addsub_req,
    output logic                 addsub_mode,
    output logic [WIDTH-1:0]     addsub_a,
    output logic [WIDTH-1:0]     addsub_b,
    input  logic                 addsub_ready,
    input  logic [WIDTH-1:0]     addsub_res
);

    localparam int unsigned RW = WIDTH / 2;
    localparam logic [WIDTH-1:0] M_INIT = WIDTH'(1) << (WIDTH - 2);

    sqrt_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_x, w_x_nxt;
    logic [WIDTH-1:0]   r_y, w_y_nxt;
    logic [WIDTH-1:0]   r_m, w_m_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [RW-1:0]      r_y_out, w_y_out_nxt;
    logic [RW:0]        r_rem, w_rem_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_req;
    logic [WIDTH-1:0]   w_b;

    // Trial subtrahend for the current iteration
    assign w_b = r_y | r_m;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_m_nxt     = r_m;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_y_out_nxt = r_y_out;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_x_nxt     = x_bi;
                    w_y_nxt     = '0;
                    w_m_nxt     = M_INIT;
                    w_state_nxt = ST_WORK;
                end
            end
            ST_WORK: begin
                if (r_m == '0) begin
                    w_y_out_nxt = r_y[RW-1:0];
                    w_rem_nxt   = r_x[RW:0];
                    w_state_nxt = ST_DONE;
                end else if (r_x >= w_b) begin
                    w_a_nxt     = r_x;
                    w_b_nxt     = w_b;
                    w_y_nxt     = (r_y >> 1) | r_m;
                    w_m_nxt     = r_m >> 2;
                    w_state_nxt = ST_WAIT_SUB;
                end else begin
                    w_y_nxt     = r_y >> 1;
                    w_m_nxt     = r_m >> 2;
                end
            end
            ST_WAIT_SUB: begin
                if (addsub_ready) begin
                    w_x_nxt     = addsub_res;
                    w_state_nxt = ST_WORK;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs (status derived from the upcoming state)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_x     <= '0;
            r_y     <= '0;
            r_m     <= M_INIT;
            r_a     <= '0;
            r_b     <= '0;
            r_y_out <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_m     <= w_m_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_y_out <= w_y_out_nxt;
            r_rem   <= w_rem_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_req   <= (w_state_nxt == ST_WAIT_SUB);
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign y_bo        = r_y_out;
    assign rem_bo      = r_rem;
    assign addsub_req  = r_req;
    assign addsub_mode = ADDSUB_SUB;
    assign addsub_a    = r_a;
    assign addsub_b    = r_b;

endmodule

// File: doc/sqrt_param.md
Name: sqrt_param

Overview:
- Parametrised iterative integer square root: y = floor(sqrt(x)), remainder r = x - y*y.
- Operand width WIDTH is generic; the result and remainder are returned together with a one-cycle done pulse.
- Contains no subtractor of its own. Every subtraction goes through the team's shared add/sub unit using the req/ready handshake, so one adder can serve several arithmetic blocks.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and at least 4. Root width RW = WIDTH/2. Remainder width = RW+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a new operation. Sampled only in IDLE.
- x_bi  in  WIDTH  radicand. Captured on the start edge.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse; y_bo and rem_bo are valid from this cycle on.
- y_bo  out  RW  root. Held until the next done.
- rem_bo  out  RW+1  remainder. Held until the next done.
- addsub_req  out  1  request to the shared add/sub unit.
- addsub_mode  out  1  operation select; 0 = subtract (a - b). Always driven 0 by this block.
- addsub_a  out  WIDTH  minuend.
- addsub_b  out  WIDTH  subtrahend.
- addsub_ready  in  1  add/sub result valid.
- addsub_res  in  WIDTH  add/sub result.

Behaviour:
- Reset values: state=IDLE; m=1<<(WIDTH-2); x=0; y=0; y_bo=0; rem_bo=0; done_o=0; addsub_mode=0; addsub_a=0; addsub_b=0.
- Reset acts immediately from any state. An operation in progress is abandoned and no done is produced.
- Internal registers: x (WIDTH bits), y (WIDTH bits), m (WIDTH bits). Combinational b = y | m.
- States: IDLE, WORK, WAIT_SUB, DONE.
- IDLE:
  - On start_i: x <= x_bi, y <= 0, m <= 1<<(WIDTH-2), go to WORK.
  - start_i in any other state is ignored, not queued.
- WORK, when m == 0:
  - y_bo <= y[RW-1:0], rem_bo <= x[RW:0], go to DONE.
- WORK, when m != 0 and x >= b (unsigned compare):
  - addsub_a <= x, addsub_b <= b, addsub_mode <= 0.
  - y <= (y>>1) | m, m <= m>>2, go to WAIT_SUB.
- WORK, when m != 0 and x < b:
  - y <= y>>1, m <= m>>2, stay in WORK.
- WAIT_SUB:
  - addsub_req = 1, combinational from state. addsub_a and addsub_b are stable for the whole request.
  - On a clock edge with addsub_ready = 1: x <= addsub_res, go to WORK.
  - Any number of wait cycles is legal.
  - addsub_ready outside WAIT_SUB is ignored.
- DONE: done_o = 1 for exactly one cycle, busy_o = 1, then go to IDLE.
- Latency: let k = number of subtractions and S = extra ready-wait cycles beyond the first.
  - There are RW iterations; each subtracting iteration costs one extra WAIT_SUB cycle.
  - done_o is high in the cycle after edge RW+1+k+S, where edge 0 is the start edge.
  - Zero-wait add/sub unit: worst case (k = RW) is 2*RW+2 cycles from the start edge to the done cycle.
- Width rules:
  - The remainder never exceeds 2*y, so it fits in RW+1 bits.
  - x >= b is a plain unsigned WIDTH-bit compare; no overflow is possible.
- A new start is accepted on the first IDLE cycle after DONE, i.e. back-to-back operations leave one idle cycle between them.

Decomposition:
- Shared include sqrt_defs.vh: state encodings (2 bits) and the ADDSUB_SUB = 0 / ADDSUB_ADD = 1 mode constants. The same mode constants are used by the other add/sub clients.
- No sub-module. The datapath is a compare, two shifts and an OR.
- Arbitration of the shared add/sub unit between clients lives outside this block.

Test Plan:
- WIDTH=16, x=0 -> y_bo=0, rem_bo=0; k=0 and done_o appears exactly 10 cycles after the start edge.
- WIDTH=16, x=144 -> y_bo=12, rem_bo=0. Also x=145 -> y_bo=12, rem_bo=1.
- WIDTH=16, x=65535 with addsub_ready held high -> y_bo=255, rem_bo=510, k=8, done_o 18 cycles after start. Check addsub_req pulses exactly 8 times.
- Same x=65535 with addsub_ready delayed 3 cycles per request -> identical results, done_o 24 cycles later than the start edge plus 18 (i.e. +24 extra wait cycles). Check addsub_a/b are stable while addsub_req is high.
- Start pulsed again mid-operation with a different x_bi -> ignored; the result belongs to the first operand. Then assert rst_i low mid-WAIT_SUB -> all outputs return to reset values with no done_o, and the next start computes correctly.
- WIDTH=8 instance, exhaustive x = 0..255 -> y_bo*y_bo + rem_bo == x and (y_bo+1)^2 > x for every value, compared against a bench reference model.
